// File: rtl/fetch_unit.sv
// Instruction fetch stage: doubleword reads split into 32-bit
// instructions, buffered and handed to decode over valid/ready.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] instr_reg,
    output logic [63:0] ifid_npc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] SLOT_LIM = (AW+1)'(BUF_DEPTH - 2);
    localparam logic [31:0] BUBBLE = 32'h0000_00FF;

    typedef enum logic [1:0] {REQ, WAIT, DRAIN, HALT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   pc;
    logic [31:0]   buf_ins [BUF_DEPTH];
    logic [63:0]   buf_npc [BUF_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   push_n;
    logic [AW:0]   pop_n;
    logic          busy;
    logic          rst_q;

    logic req_fire;
    logic redir;
    logic take_resp;
    logic pop;
    logic halt_hit;
    logic flush;
    logic two;

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign redir     = redirect_valid && (state != HALT);
    assign take_resp = (state == WAIT) && mem_resp_valid && !redir;
    assign pop       = if_valid && id_ready && !redir;
    assign halt_hit  = pop && (instr_reg == 32'h0);
    assign flush     = redir || halt_hit || (state == HALT);
    assign two       = !pc[2];
    assign push_n    = take_resp ? (two ? (AW+1)'(2) : (AW+1)'(1)) : '0;
    assign pop_n     = {{AW{1'b0}}, pop};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= REQ;
        else       state <= state_nxt;
    end

    // Next-state: redirect beats halt, halt beats normal progress
    always_comb begin
        state_nxt = state;
        unique case (state)
            REQ: begin
                if (redir)         state_nxt = req_fire ? DRAIN : REQ;
                else if (halt_hit) state_nxt = HALT;
                else if (req_fire) state_nxt = WAIT;
            end
            WAIT: begin
                if (redir)               state_nxt = mem_resp_valid ? REQ : DRAIN;
                else if (halt_hit)       state_nxt = HALT;
                else if (mem_resp_valid) state_nxt = REQ;
            end
            DRAIN: begin
                if (mem_resp_valid) state_nxt = REQ;
            end
            HALT: state_nxt = HALT;
        endcase
    end

    // Outputs: request gating and IF/ID view of the FIFO head
    always_comb begin
        mem_req_valid = (state == REQ) && (count <= SLOT_LIM)
                        && !busy && !reset;
        mem_req_addr  = pc & ~64'h7;
        if_valid      = (state != HALT) && (count != '0);
        halted        = (state == HALT);
        instr_reg     = BUBBLE;
        ifid_npc      = 64'h0;
        if (if_valid) begin
            instr_reg = buf_ins[rd_ptr];
            ifid_npc  = buf_npc[rd_ptr];
        end
    end

    // PC, outstanding-read tracking and delivered-instruction count
    always_ff @(posedge clk) begin
        rst_q <= reset;
        if (reset) begin
            pc          <= RESET_PC & ~64'h3;
            fetch_count <= '0;
            // a short reset can land while a read is in flight; keep
            // the marker so its late response is dropped, not pushed
            busy        <= busy && !mem_resp_valid && !rst_q;
        end else begin
            if (req_fire)            busy <= 1'b1;
            else if (mem_resp_valid) busy <= 1'b0;
            if (pop) fetch_count <= fetch_count + 32'd1;
            if (redir)
                pc <= redirect_pc & ~64'h3;
            else if (take_resp)
                pc <= pc + (two ? 64'd8 : 64'd4);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_n[AW-1:0];
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + push_n - pop_n;
        end
    end

    // FIFO storage: low word only when the PC is 8-byte aligned
    always_ff @(posedge clk) begin
        if (take_resp) begin
            if (two) begin
                buf_ins[wr_ptr]         <= mem_resp_data[31:0];
                buf_npc[wr_ptr]         <= pc + 64'd4;
                buf_ins[wr_ptr + AW'(1)] <= mem_resp_data[63:32];
                buf_npc[wr_ptr + AW'(1)] <= pc + 64'd8;
            end else begin
                buf_ins[wr_ptr] <= mem_resp_data[63:32];
                buf_npc[wr_ptr] <= pc + 64'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected
// IF/ID pairs, a monitor pops and compares on every handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] instr_reg;
    logic [63:0] ifid_npc;
    logic        halted;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] npc;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] acc_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          lat = 0;
    bit          mem_stall = 1'b0;
    bit          zero_en = 1'b0;
    logic [63:0] exp_pc;
    logic [31:0] exp_fc;

    fetch_unit #(.RESET_PC(64'h0), .BUF_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .instr_reg      (instr_reg),
        .ifid_npc       (ifid_npc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // program image: two fixed words at 0, optional zero word at 0x10
    function automatic logic [31:0] instr_at(input logic [63:0] a);
        if (a == 64'h0) return 32'h00100093;
        if (a == 64'h4) return 32'h00500093;
        if (zero_en && a == 64'h10) return 32'h0;
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    // allow exactly n pops, queueing the sequential stream from exp_pc
    task automatic release_n(input int n);
        int   budget;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ins = instr_at(exp_pc);
            e.npc = exp_pc + 64'd4;
            expq.push_back(e);
            exp_pc += 64'd4;
        end
        exp_fc += 32'(n);
        budget = 200;
        id_ready = 1'b1;
        while (fetch_count != exp_fc && budget > 0) begin
            tick();
            budget--;
        end
        id_ready = 1'b0;
        chk("fetch_count", 64'(fetch_count), 64'(exp_fc));
    endtask

    task automatic wait_req(input string name);
        int b = 50;
        while (!mem_req_valid && b > 0) begin
            tick();
            b--;
        end
        chk(name, 64'(mem_req_valid), 64'd1);
    endtask

    task automatic wait_acc(input string name);
        int b = 50;
        while (!(mem_req_valid && mem_req_ready) && b > 0) begin
            tick();
            b--;
        end
        chk(name, 64'(mem_req_valid && mem_req_ready), 64'd1);
    endtask

    // memory: one response per accepted request, lat extra cycles
    initial begin
        logic [63:0] m_addr;
        int          m_wait;
        bit          m_pend;
        m_addr = '0;
        m_wait = 0;
        m_pend = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (m_pend) begin
                if (m_wait == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = {instr_at(m_addr + 64'd4),
                                      instr_at(m_addr)};
                    m_pend = 1'b0;
                end else begin
                    m_wait--;
                end
            end
            mem_req_ready = !mem_stall;
            if (mem_req_valid && mem_req_ready && !reset) begin
                m_pend = 1'b1;
                m_wait = lat;
                m_addr = mem_req_addr;
                acc_q.push_back(mem_req_addr);
            end
        end
    end

    // monitor: compare every head consumed by decode
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && if_valid && id_ready && !redirect_valid) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pop: got %h/%h required none",
                             instr_reg, ifid_npc);
                end else begin
                    e = expq.pop_front();
                    chk("head_instr", 64'(instr_reg), 64'(e.ins));
                    chk("head_npc", ifid_npc, e.npc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        exp_pc = '0;
        exp_fc = '0;
        repeat (3) begin
            tick();
            chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        end
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_instr", 64'(instr_reg), 64'hFF);
        chk("rst_npc", ifid_npc, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);

        // first fetch from RESET_PC
        reset = 1'b0;
        #1;
        chk("first_req_valid", 64'(mem_req_valid), 64'd1);
        chk("first_req_addr", mem_req_addr, 64'h0);
        release_n(2);
        chk("acc0_addr", acc_q[0], 64'h0);
        chk("acc1_addr", acc_q[1], 64'h8);

        // decode stalled: FIFO fills to depth, head stable
        repeat (10) begin
            tick();
            chk("bp_req_valid", 64'(mem_req_valid), 64'd0);
            chk("bp_instr", 64'(instr_reg), 64'(instr_at(exp_pc)));
        end
        chk("bp_acc_count", 64'(acc_q.size()), 64'd3);
        chk("bp_last_acc", acc_q[2], 64'h10);
        release_n(6);

        // memory not ready: request held, then redirected
        settle(8);
        mem_stall = 1'b1;
        release_n(2);
        wait_req("stall_req");
        repeat (5) begin
            chk("stall_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_addr", mem_req_addr, 64'h30);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h203;
        tick();
        redirect_valid = 1'b0;
        chk("stall_redir_addr", mem_req_addr, 64'h200);
        chk("stall_redir_valid", 64'(mem_req_valid), 64'd1);
        chk("stall_redir_flush", 64'(if_valid), 64'd0);
        mem_stall = 1'b0;
        exp_pc = 64'h200;
        release_n(4);

        // redirect while a read is outstanding -> drain
        settle(8);
        lat = 2;
        release_n(2);
        wait_acc("d_acc");
        chk("d_req_addr", mem_req_addr, 64'h220);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h10C;
        tick();
        redirect_valid = 1'b0;
        chk("drain_if_valid", 64'(if_valid), 64'd0);
        chk("drain_req_valid", 64'(mem_req_valid), 64'd0);
        wait_req("d_req");
        chk("d_redir_addr", mem_req_addr, 64'h108);
        exp_pc = 64'h10C;
        release_n(3);
        lat = 0;

        // redirect, response and pop all in one cycle
        settle(16);
        release_n(2);
        wait_acc("e_acc");
        chk("e_req_addr", mem_req_addr, 64'h128);
        tick();
        chk("e_if_valid", 64'(if_valid), 64'd1);
        chk("e_head", 64'(instr_reg), 64'(instr_at(64'h120)));
        redirect_valid = 1'b1;
        redirect_pc = 64'h300;
        id_ready = 1'b1;
        #2;
        chk("e_resp_same", 64'(mem_resp_valid), 64'd1);
        tick();
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        chk("e_count_held", 64'(fetch_count), 64'(exp_fc));
        chk("e_flush", 64'(if_valid), 64'd0);
        chk("e_req_valid", 64'(mem_req_valid), 64'd1);
        chk("e_req_addr2", mem_req_addr, 64'h300);
        exp_pc = 64'h300;
        release_n(4);

        // zero word at 0x10 halts the stage
        settle(8);
        zero_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 64'h8;
        release_n(3);
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_if_valid", 64'(if_valid), 64'd0);
        chk("halt_instr", 64'(instr_reg), 64'hFF);
        chk("halt_npc", ifid_npc, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h400;
        tick();
        redirect_valid = 1'b0;
        repeat (4) begin
            chk("halt_stay", 64'(halted), 64'd1);
            chk("halt_no_req", 64'(mem_req_valid), 64'd0);
            chk("halt_count", 64'(fetch_count), 64'(exp_fc));
            tick();
        end

        // reset leaves HALT and restarts at RESET_PC
        reset = 1'b1;
        tick();
        tick();
        chk("rst2_count", 64'(fetch_count), 64'd0);
        chk("rst2_halted", 64'(halted), 64'd0);
        chk("rst2_if_valid", 64'(if_valid), 64'd0);
        chk("rst2_req_valid", 64'(mem_req_valid), 64'd0);
        reset = 1'b0;
        zero_en = 1'b0;
        #1;
        chk("rst2_req_valid1", 64'(mem_req_valid), 64'd1);
        chk("rst2_req_addr", mem_req_addr, 64'h0);
        exp_pc = 64'h0;
        exp_fc = 32'h0;
        release_n(2);
        settle(4);
        chk("exp_queue_empty", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
